// File: rtl/fp_mul_pipe.sv
// Three-stage single-precision multiplier with a reduced-width significand
// datapath, valid/ready handshake, flush-to-zero and selectable truncate/round.
module fp_mul_pipe #(
   parameter int MAN_W       = 13,
   parameter int RND_DEFAULT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        rnd_mode,
   output logic [31:0] result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  flags
);

   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   // Product bits from the MSB down to the lowest possible round bit.
   localparam int TOP_W  = MAN_W + 3;
   localparam logic RND_RST = 1'(RND_DEFAULT);

   typedef enum logic [1:0] {
      CLS_NORM,
      CLS_INVALID,
      CLS_INF,
      CLS_ZERO
   } cls_e;

   // Whole pipeline advances together; a full, blocked output stalls everything.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // ---------------- S1: unpack / classify ----------------
   logic                    s1_v_q, s1_v_d;
   logic                    s1_sign_q, s1_sign_d;
   cls_e                    s1_cls_q, s1_cls_d;
   logic signed [9:0]       s1_exp_q, s1_exp_d;
   logic [SIG_W-1:0]        s1_sig_a_q, s1_sig_a_d;
   logic [SIG_W-1:0]        s1_sig_b_q, s1_sig_b_d;
   logic                    s1_rnd_q, s1_rnd_d;

   logic [7:0] e1, e2;
   logic       nan1, nan2, inf1, inf2, zero1, zero2;

   assign e1 = num1[30:23];
   assign e2 = num2[30:23];

   // NOTE: every signal written in always_comb gets a value on every path
   // (defaults first) so no latch is inferred.
   always_comb begin
      nan1  = (e1 == 8'hFF) && (num1[22:0] != 23'd0);
      nan2  = (e2 == 8'hFF) && (num2[22:0] != 23'd0);
      inf1  = (e1 == 8'hFF) && (num1[22:0] == 23'd0);
      inf2  = (e2 == 8'hFF) && (num2[22:0] == 23'd0);
      zero1 = (e1 == 8'h00);
      zero2 = (e2 == 8'h00);

      s1_cls_d = CLS_NORM;
      if (nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1)) s1_cls_d = CLS_INVALID;
      else if (inf1 || inf2)                                  s1_cls_d = CLS_INF;
      else if (zero1 || zero2)                                s1_cls_d = CLS_ZERO;

      s1_sign_d  = num1[31] ^ num2[31];
      s1_exp_d   = 10'(e1) + 10'(e2) - 10'd127;
      s1_sig_a_d = {1'b1, num1[22 -: MAN_W]};
      s1_sig_b_d = {1'b1, num2[22 -: MAN_W]};
      s1_rnd_d   = rnd_mode;
      s1_v_d     = advance ? in_valid : s1_v_q;
   end

   // ---------------- S2: significand multiply ----------------
   logic                    s2_v_q, s2_v_d;
   logic                    s2_sign_q;
   cls_e                    s2_cls_q;
   logic signed [9:0]       s2_exp_q;
   logic [TOP_W-1:0]        s2_prod_q, s2_prod_d;
   logic                    s2_rnd_q;
   logic [PROD_W-1:0]       prod_full;

   always_comb begin
      prod_full = PROD_W'(s1_sig_a_q) * PROD_W'(s1_sig_b_q);
      s2_prod_d = TOP_W'(prod_full >> (MAN_W - 1));
      s2_v_d    = advance ? s1_v_q : s2_v_q;
   end

   // ---------------- S3: normalise / round / pack ----------------
   logic                    s3_v_q, s3_v_d;
   logic [31:0]             result_q, result_d;
   logic [3:0]              flags_q, flags_d;

   logic                    msb, guard;
   logic [MAN_W-1:0]        man_n, man_f;
   logic [MAN_W:0]          man_r;
   logic signed [9:0]       exp_f;
   logic [22:0]             mant_pk;

   always_comb begin
      msb   = s2_prod_q[TOP_W-1];
      man_n = msb ? s2_prod_q[TOP_W-2 -: MAN_W] : s2_prod_q[TOP_W-3 -: MAN_W];
      guard = msb ? s2_prod_q[1] : s2_prod_q[0];
      man_r = {1'b0, man_n} + (MAN_W+1)'(s2_rnd_q & guard);
      // A rounding carry-out wraps the mantissa to zero and bumps the exponent.
      exp_f   = s2_exp_q + 10'(msb) + 10'(man_r[MAN_W]);
      man_f   = man_r[MAN_W] ? '0 : man_r[MAN_W-1:0];
      mant_pk = 23'(man_f) << (23 - MAN_W);

      result_d = {s2_sign_q, exp_f[7:0], mant_pk};
      flags_d  = 4'b0000;
      unique case (s2_cls_q)
         CLS_INVALID: begin
            result_d = {s2_sign_q, 8'hFF, 23'h400000};
            flags_d  = 4'b1000;
         end
         CLS_INF:  result_d = {s2_sign_q, 8'hFF, 23'd0};
         CLS_ZERO: begin
            result_d = {s2_sign_q, 31'd0};
            flags_d  = 4'b0001;
         end
         default: begin
            if (exp_f >= 10'sd255) begin
               result_d = {s2_sign_q, 8'hFF, 23'd0};
               flags_d  = 4'b0100;
            end else if (exp_f <= 10'sd0) begin
               result_d = {s2_sign_q, 31'd0};
               flags_d  = 4'b0011;
            end
         end
      endcase

      s3_v_d = advance ? s2_v_q : s3_v_q;
   end

   // ---------------- control and output registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s3_v_q   <= 1'b0;
         s1_rnd_q <= RND_RST;
         s2_rnd_q <= RND_RST;
         result_q <= 32'd0;
         flags_q  <= 4'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // stage samples the values from before this edge.
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         s3_v_q <= s3_v_d;
         if (advance && in_valid) s1_rnd_q <= s1_rnd_d;
         if (advance && s1_v_q)   s2_rnd_q <= s1_rnd_q;
         if (advance && s2_v_q) begin
            result_q <= result_d;
            flags_q  <= flags_d;
         end
      end
   end

   // NOTE: wide datapath registers carry no reset; they are only ever observed
   // behind a valid bit that is itself reset.
   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         s1_sign_q  <= s1_sign_d;
         s1_cls_q   <= s1_cls_d;
         s1_exp_q   <= s1_exp_d;
         s1_sig_a_q <= s1_sig_a_d;
         s1_sig_b_q <= s1_sig_b_d;
      end
      if (advance && s1_v_q) begin
         s2_sign_q <= s1_sign_q;
         s2_cls_q  <= s1_cls_q;
         s2_exp_q  <= s1_exp_q;
         s2_prod_q <= s2_prod_d;
      end
   end

   assign out_valid = s3_v_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed, scoreboarded bench for fp_mul_pipe: latency, rounding, exceptions,
// backpressure and mid-operation reset.
module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] num1, num2;
   logic        in_valid, in_ready, rnd_mode;
   logic [31:0] result;
   logic        out_valid, out_ready;
   logic [3:0]  flags;

   fp_mul_pipe #(.MAN_W(13), .RND_DEFAULT(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .num1      (num1),
      .num2      (num2),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rnd_mode  (rnd_mode),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        rnd;
      logic [31:0] res;
      logic [3:0]  flg;
      string       tag;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      string       tag;
   } exp_t;

   localparam int NUM_V = 18;
   vec_t        vecs [NUM_V];
   exp_t        sb [$];
   exp_t        cur_exp;
   int          n_vec  = 0;
   int          n_fail = 0;
   bit          accepted;
   bit          prev_stall = 1'b0;
   logic [35:0] held;
   int          idx;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int i);
      num1     = vecs[i].a;
      num2     = vecs[i].b;
      rnd_mode = vecs[i].rnd;
      in_valid = 1'b1;
      cur_exp  = '{vecs[i].res, vecs[i].flg, vecs[i].tag};
   endtask

   // Called at the falling edge: records handshakes that the next rising edge completes.
   task automatic observe();
      exp_t e;
      accepted = 1'b0;
      if (out_valid && !out_ready) begin
         if (prev_stall) check("stall_hold", {result, flags}, held);
         held       = {result, flags};
         prev_stall = 1'b1;
      end else begin
         prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
         sb.push_back(cur_exp);
         accepted = 1'b1;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            check({e.tag, "_data"}, {result, flags}, {e.res, e.flg});
         end
      end
   endtask

   // One op in an empty pipe: not valid after 1 or 2 edges, valid after the 3rd.
   task automatic run_single(input int i);
      drive(i);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 3)     check({vecs[i].tag, "_valid"}, out_valid, 1'b1);
         else if (k > 0) check({vecs[i].tag, "_early"}, out_valid, 1'b0);
         observe();
         @(posedge clk); #1;
         if (k == 0) in_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 4'b0000, "mul_2x3"};
      vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 4'b0000, "mul_1p5sq"};
      vecs[2]  = '{32'h3FC00000, 32'h3F800400, 1'b0, 32'h3FC00400, 4'b0000, "rnd_trunc"};
      vecs[3]  = '{32'h3FC00000, 32'h3F800400, 1'b1, 32'h3FC00800, 4'b0000, "rnd_half_up"};
      vecs[4]  = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0100, "ovf"};
      vecs[5]  = '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011, "unf"};
      vecs[6]  = '{32'h00000000, 32'hC0000000, 1'b0, 32'h80000000, 4'b0001, "zero_in"};
      vecs[7]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, "inf_x_zero"};
      vecs[8]  = '{32'h3FFFF800, 32'h3F800400, 1'b0, 32'h3FFFFC00, 4'b0000, "carry_trunc"};
      vecs[9]  = '{32'h3FFFF800, 32'h3F800400, 1'b1, 32'h40000000, 4'b0000, "rnd_carry"};
      vecs[10] = '{32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'b0000, "neg"};
      vecs[11] = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000, "inf_norm"};
      vecs[12] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "nan_in"};
      vecs[13] = '{32'h00400000, 32'h40000000, 1'b0, 32'h00000000, 4'b0001, "denorm"};
      vecs[14] = '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 4'b0000, "max_exp"};
      vecs[15] = '{32'h00800000, 32'h3F800000, 1'b0, 32'h00800000, 4'b0000, "min_exp"};
      vecs[16] = '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'b0011, "exp_zero"};
      vecs[17] = '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 4'b0100, "exp_255"};

      rst_n     = 1'b0;
      num1      = '0;
      num2      = '0;
      rnd_mode  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_result",    result,    32'd0);
      check("rst_flags",     flags,     4'd0);
      rst_n = 1'b1;

      // Directed single operations, each with its own latency check
      for (int i = 0; i < NUM_V; i++) run_single(i);

      // Back-to-back stream of 6 with a 3-cycle downstream stall
      idx = 0;
      for (int c = 0; c < 40 && !(idx == 6 && sb.size() == 0); c++) begin
         if (idx < 6) drive(idx);
         else         in_valid = 1'b0;
         out_ready = !(c >= 4 && c <= 6);
         @(negedge clk);
         if (c >= 4 && c <= 6) begin
            check("bp_stall_valid",    out_valid, 1'b1);
            check("bp_stall_in_ready", in_ready,  1'b0);
         end
         observe();
         @(posedge clk); #1;
         if (accepted) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_all_accepted", 36'(idx), 36'd6);
      check("bp_drained",      36'(sb.size()), 36'd0);

      // Reset with two operations in flight
      drive(0);
      @(negedge clk); observe();
      @(posedge clk); #1;
      drive(1);
      @(negedge clk); observe();
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      check("rst_mid_pre_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", out_valid, 1'b0);
      check("rst_mid_result",    result,    32'd0);
      check("rst_mid_flags",     flags,     4'd0);
      check("rst_mid_in_ready",  in_ready,  1'b1);
      sb.delete();
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_hold_valid", out_valid, 1'b0);
      end
      rst_n = 1'b1;
      run_single(10);
      repeat (4) begin
         @(negedge clk);
         check("rst_no_stale", out_valid, 1'b0);
         observe();
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
